// File: rtl/pipe_exe_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, writeback sources,
// divider FSM states and the ID/EXE latch layout.
package pipe_exe_pkg;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [3:0] {
        ALU_ADDU = 4'b0000,
        ALU_SUBU = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_LUI  = 4'b1000,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_SRA  = 4'b1100,
        ALU_SLL  = 4'b1110,
        ALU_SRL  = 4'b1111
    } aluc_e;

    typedef enum logic [2:0] {
        RF_ALU = 3'd0,
        RF_DM  = 3'd1,
        RF_HI  = 3'd2,
        RF_LO  = 3'd3,
        RF_PC  = 3'd4
    } rfsrc_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic        w_rf;
        logic        w_dm;
        logic        w_hi;
        logic        w_lo;
        logic        div;
        logic        sign;
        logic        is_goto;
        aluc_e       aluc;
        logic        asrc;
        logic        bsrc;
        rfsrc_e      rfsrc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rn;
    } idex_t;

endpackage

// File: rtl/pipe_div.sv
// Multi-cycle restoring divider on operand magnitudes with sign fix-up,
// divide-by-zero handling and a one-cycle DONE result strobe.
module pipe_div #(
    parameter int DIV_CYCLES = pipe_exe_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);
    import pipe_exe_pkg::*;

    localparam int CW = $clog2(DIV_CYCLES + 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rem_q, quo_q, dvs_q, dvd_q, q_q, r_q;
    logic          qneg_q, rneg_q, dz_q;
    logic          last_step;
    logic [32:0]   trial;
    logic [31:0]   rem_nx, quo_nx;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    assign last_step = (cnt_q == CW'(DIV_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= DIV_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start) state_d = DIV_BUSY;
            DIV_BUSY: if (last_step) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy = ((state_q == DIV_IDLE) && start) || (state_q == DIV_BUSY);
        done = (state_q == DIV_DONE);
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        if (!trial[32]) begin
            rem_nx = trial[31:0];
            quo_nx = {quo_q[30:0], 1'b1};
        end else begin
            rem_nx = {rem_q[30:0], quo_q[31]};
            quo_nx = {quo_q[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            dvd_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        quo_q  <= magnitude(a, sign);
                        dvs_q  <= magnitude(b, sign);
                        dvd_q  <= a;
                        dz_q   <= (b == 32'd0);
                        qneg_q <= sign && (a[31] ^ b[31]);
                        rneg_q <= sign && a[31];
                    end
                end
                DIV_BUSY: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        q_q <= dz_q ? 32'hFFFF_FFFF : (qneg_q ? 32'd0 - quo_nx : quo_nx);
                        r_q <= dz_q ? dvd_q : (rneg_q ? 32'd0 - rem_nx : rem_nx);
                    end
                end
                default: ;
            endcase
        end
    end

    assign q = q_q;
    assign r = r_q;

endmodule

// File: rtl/pipe_exe.sv
// Execute stage: ID/EXE latch with bubble insertion, zero-latency ALU and link
// path, and a stalling multi-cycle divider feeding HI/LO.
module pipe_exe #(
    parameter int DIV_CYCLES = pipe_exe_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Dstall,
    input  logic        Dw_rf,
    input  logic        Dw_dm,
    input  logic        Dw_hi,
    input  logic        Dw_lo,
    input  logic        Ddiv,
    input  logic        Dsign,
    input  logic        DisGoto,
    input  logic [3:0]  Daluc,
    input  logic        Dasource,
    input  logic        Dbsource,
    input  logic [2:0]  Drfsource,
    input  logic [31:0] DRs,
    input  logic [31:0] DRt,
    input  logic [31:0] Dimm,
    input  logic [31:0] Dpc4,
    input  logic [4:0]  Drn,
    output logic [31:0] Ealu,
    output logic [4:0]  Ern,
    output logic        Ew_rf,
    output logic        Ew_dm,
    output logic        EisGoto,
    output logic [2:0]  Erfsource,
    output logic [31:0] Ehi,
    output logic [31:0] Elo,
    output logic        Ew_hi,
    output logic        Ew_lo,
    output logic [31:0] ERt,
    output logic        div_busy
);
    import pipe_exe_pkg::*;

    idex_t              ex_q, ex_d;
    logic signed [31:0] opa, opb, sum, dif;
    logic [31:0]        alu_y;
    logic               ovf;
    logic               div_done;
    logic               div_hold;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // A bubble also drops the link flag, since a link implies a register write.
    always_comb begin
        ex_d = ex_q;
        if (!div_busy) begin
            ex_d.w_rf    = Dw_rf && !Dstall;
            ex_d.w_dm    = Dw_dm && !Dstall;
            ex_d.w_hi    = Dw_hi && !Dstall;
            ex_d.w_lo    = Dw_lo && !Dstall;
            ex_d.div     = Ddiv && !Dstall;
            ex_d.is_goto = DisGoto && !Dstall;
            ex_d.sign    = Dsign;
            ex_d.aluc    = aluc_e'(Daluc);
            ex_d.asrc    = Dasource;
            ex_d.bsrc    = Dbsource;
            ex_d.rfsrc   = rfsrc_e'(Drfsource);
            ex_d.rs      = DRs;
            ex_d.rt      = DRt;
            ex_d.imm     = Dimm;
            ex_d.pc4     = Dpc4;
            ex_d.rn      = Drn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    // EXE: combinational ALU on the latched operands
    always_comb begin
        opa   = ex_q.asrc ? $signed({27'b0, ex_q.imm[10:6]}) : $signed(ex_q.rs);
        opb   = ex_q.bsrc ? $signed(ex_q.imm) : $signed(ex_q.rt);
        sum   = opa + opb;
        dif   = opa - opb;
        ovf   = 1'b0;
        alu_y = 32'd0;
        case (ex_q.aluc)
            ALU_ADDU: alu_y = sum;
            ALU_ADD: begin
                alu_y = sum;
                ovf   = add_ovf(opa[31], opb[31], sum[31]);
            end
            ALU_SUBU: alu_y = dif;
            ALU_SUB: begin
                alu_y = dif;
                ovf   = add_ovf(opa[31], ~opb[31], dif[31]);
            end
            ALU_AND:  alu_y = opa & opb;
            ALU_OR:   alu_y = opa | opb;
            ALU_XOR:  alu_y = opa ^ opb;
            ALU_NOR:  alu_y = ~(opa | opb);
            ALU_LUI:  alu_y = {opb[15:0], 16'h0000};
            ALU_SLT:  alu_y = {31'b0, opa < opb};
            ALU_SLTU: alu_y = {31'b0, $unsigned(opa) < $unsigned(opb)};
            ALU_SRA:  alu_y = opb >>> opa[4:0];
            ALU_SLL:  alu_y = opb << opa[4:0];
            ALU_SRL:  alu_y = $unsigned(opb) >> opa[4:0];
            default:  alu_y = 32'd0;
        endcase
    end

    pipe_div #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .start(ex_q.div),
        .sign (ex_q.sign),
        .a    (opa),
        .b    (opb),
        .busy (div_busy),
        .done (div_done),
        .q    (Elo),
        .r    (Ehi)
    );

    assign div_hold = ex_q.div && !div_done;

    always_comb begin
        Ealu      = ex_q.is_goto ? ex_q.pc4 + 32'd4 : alu_y;
        Ern       = ex_q.is_goto ? 5'd31 : ex_q.rn;
        Ew_rf     = ex_q.is_goto || (ex_q.w_rf && !ovf && !div_hold);
        Ew_dm     = ex_q.w_dm && !div_hold;
        Ew_hi     = ex_q.div ? div_done : ex_q.w_hi;
        Ew_lo     = ex_q.div ? div_done : ex_q.w_lo;
        EisGoto   = ex_q.is_goto;
        Erfsource = ex_q.rfsrc;
        ERt       = ex_q.rt;
    end

endmodule

// File: tb/tb_pipe_exe.sv
// Bench for pipe_exe: directed and random ALU/divider instructions against a
// behavioural model, including bubbles, back-to-back divides and reset mid-divide.
module tb_pipe_exe;

    localparam int NDIV = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        Dstall, Dw_rf, Dw_dm, Dw_hi, Dw_lo, Ddiv, Dsign, DisGoto;
    logic [3:0]  Daluc;
    logic        Dasource, Dbsource;
    logic [2:0]  Drfsource;
    logic [31:0] DRs, DRt, Dimm, Dpc4;
    logic [4:0]  Drn;
    logic [31:0] Ealu, Ehi, Elo, ERt;
    logic [4:0]  Ern;
    logic        Ew_rf, Ew_dm, EisGoto, Ew_hi, Ew_lo, div_busy;
    logic [2:0]  Erfsource;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pipe_exe #(.DIV_CYCLES(NDIV)) dut (
        .clk(clk), .rst(rst), .Dstall(Dstall), .Dw_rf(Dw_rf), .Dw_dm(Dw_dm),
        .Dw_hi(Dw_hi), .Dw_lo(Dw_lo), .Ddiv(Ddiv), .Dsign(Dsign), .DisGoto(DisGoto),
        .Daluc(Daluc), .Dasource(Dasource), .Dbsource(Dbsource), .Drfsource(Drfsource),
        .DRs(DRs), .DRt(DRt), .Dimm(Dimm), .Dpc4(Dpc4), .Drn(Drn),
        .Ealu(Ealu), .Ern(Ern), .Ew_rf(Ew_rf), .Ew_dm(Ew_dm), .EisGoto(EisGoto),
        .Erfsource(Erfsource), .Ehi(Ehi), .Elo(Elo), .Ew_hi(Ew_hi), .Ew_lo(Ew_lo),
        .ERt(ERt), .div_busy(div_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        Dstall = 0; Dw_rf = 0; Dw_dm = 0; Dw_hi = 0; Dw_lo = 0; Ddiv = 0; Dsign = 0;
        DisGoto = 0; Daluc = 4'd0; Dasource = 0; Dbsource = 0; Drfsource = 3'd0;
        DRs = 0; DRt = 0; Dimm = 0; Dpc4 = 0; Drn = 5'd0;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input logic wrf, input logic wdm);
        clear_d();
        Daluc = op; DRs = rs; DRt = rt; Dw_rf = wrf; Dw_dm = wdm; Drn = 5'd9;
    endtask

    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] y, output logic ovf);
        longint s;
        ovf = 1'b0;
        case (op)
            4'd0:  y = a + b;
            4'd2: begin
                y = a + b;
                s = longint'(int'(a)) + longint'(int'(b));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1:  y = a - b;
            4'd3: begin
                y = a - b;
                s = longint'(int'(a)) - longint'(int'(b));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4:  y = a & b;
            4'd5:  y = a | b;
            4'd6:  y = a ^ b;
            4'd7:  y = ~(a | b);
            4'd8:  y = b * 32'd65536;
            4'd10: y = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd11: y = (a < b) ? 32'd1 : 32'd0;
            4'd12: y = 32'(int'(b) >>> a[4:0]);
            4'd14: y = b << a[4:0];
            4'd15: y = b >> a[4:0];
            default: y = 32'd0;
        endcase
    endfunction

    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0;
            end else begin
                q = 32'(int'(a) / int'(b));
                r = 32'(int'(a) % int'(b));
            end
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        clear_d();
        Ddiv = 1; Dsign = sgn; DRs = a; DRt = b; Daluc = 4'd0;
        tick();
    endtask

    // Called right after a div has been captured; returns in the DONE cycle.
    task automatic wait_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cycles = 0;
        logic leak = 1'b0;
        logic [31:0] eq, er;
        while (div_busy && cycles < 100) begin
            leak |= Ew_rf | Ew_dm | Ew_hi | Ew_lo;
            cycles++;
            tick();
        end
        ref_div(sgn, a, b, eq, er);
        chk({tag, " busy_cycles"}, 32'(cycles), 32'(NDIV + 1));
        chk({tag, " busy_write_leak"}, 32'(leak), 32'd0);
        chk({tag, " lo"}, Elo, eq);
        chk({tag, " hi"}, Ehi, er);
        chk({tag, " w_hi_done"}, 32'(Ew_hi), 32'd1);
        chk({tag, " w_lo_done"}, 32'(Ew_lo), 32'd1);
    endtask

    initial begin
        logic [31:0] ey, a, b, rs, rt, imm;
        logic        eovf, sgn;
        logic [3:0]  op;

        clear_d();
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst ealu", Ealu, 32'd0);
        chk("rst ern", 32'(Ern), 32'd0);
        chk("rst ew_rf", 32'(Ew_rf), 32'd0);
        chk("rst busy", 32'(div_busy), 32'd0);
        chk("rst hi", Ehi, 32'd0);
        chk("rst lo", Elo, 32'd0);

        drive_alu(4'b0000, 32'd7, 32'd5, 1, 0);
        tick();
        chk("addu ealu", Ealu, 32'd12);
        chk("addu ew_rf", 32'(Ew_rf), 32'd1);
        chk("addu ern", 32'(Ern), 32'd9);

        drive_alu(4'b0010, 32'h7FFF_FFFF, 32'd1, 1, 0);
        tick();
        chk("add_ovf ealu", Ealu, 32'h8000_0000);
        chk("add_ovf ew_rf", 32'(Ew_rf), 32'd0);

        drive_alu(4'b1010, 32'hFFFF_FFFD, 32'd2, 1, 0);
        tick();
        chk("slt ealu", Ealu, 32'd1);

        clear_d();
        DisGoto = 1; Dpc4 = 32'h0040_0008; Drn = 5'd3; DRs = 32'h1234;
        tick();
        chk("jal ealu", Ealu, 32'h0040_000C);
        chk("jal ern", 32'(Ern), 32'd31);
        chk("jal isgoto", 32'(EisGoto), 32'd1);
        chk("jal ew_rf", 32'(Ew_rf), 32'd1);

        drive_alu(4'b0000, 32'd1, 32'd2, 1, 1);
        Dw_hi = 1; Dw_lo = 1; DisGoto = 1; Dstall = 1;
        tick();
        chk("stall ew_rf", 32'(Ew_rf), 32'd0);
        chk("stall ew_dm", 32'(Ew_dm), 32'd0);
        chk("stall ew_hi", 32'(Ew_hi), 32'd0);
        chk("stall ew_lo", 32'(Ew_lo), 32'd0);
        chk("stall busy", 32'(div_busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            rs = $urandom(); rt = $urandom(); imm = $urandom();
            if (i % 5 == 0) begin rs = 32'h7FFF_FFF0 + 32'(i); rt = 32'h8000_0000 + 32'(i); end
            drive_alu(op, rs, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            Dasource = 1'($urandom_range(0, 1)); Dbsource = 1'($urandom_range(0, 1));
            Dimm = imm; Drn = 5'($urandom_range(0, 31)); Drfsource = 3'($urandom_range(0, 4));
            a = Dasource ? {27'd0, imm[10:6]} : rs;
            b = Dbsource ? imm : rt;
            ref_alu(op, a, b, ey, eovf);
            tick();
            chk("rnd ealu", Ealu, ey);
            chk("rnd ew_rf", 32'(Ew_rf), 32'(Dw_rf && !eovf));
            chk("rnd ew_dm", 32'(Ew_dm), 32'(Dw_dm));
            chk("rnd ert", ERt, rt);
            chk("rnd ern", 32'(Ern), 32'(Drn));
            chk("rnd rfsrc", 32'(Erfsource), 32'(Drfsource));
        end

        start_div(1, 32'hFFFF_FFF9, 32'd2);
        drive_alu(4'b0000, 32'd3, 32'd4, 1, 1);
        Dstall = 1'($urandom_range(0, 1));
        Dstall = 0;
        wait_div(1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        tick();
        chk("after_done ew_hi", 32'(Ew_hi), 32'd0);
        chk("after_done busy", 32'(div_busy), 32'd0);
        chk("after_done ealu", Ealu, 32'd7);

        a = $urandom(); b = $urandom_range(1, 1000);
        start_div(0, 32'd10, 32'd0);
        clear_d();
        Ddiv = 1; Dsign = 1; DRs = a; DRt = b;
        wait_div(0, 32'd10, 32'd0, "div_10_0");
        tick();
        chk("b2b restart busy", 32'(div_busy), 32'd1);
        chk("b2b restart ew_hi", 32'(Ew_hi), 32'd0);
        clear_d();
        wait_div(1, a, b, "div_b2b");
        tick();

        for (int i = 0; i < 6; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom(); b = (i % 2) ? $urandom() : 32'($urandom_range(1, 300));
            if (i == 0) begin sgn = 1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 1) begin sgn = 1; a = 32'hFFFF_FF00; b = 32'd0; end
            if (i == 2) begin sgn = 1; b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
            start_div(sgn, a, b);
            drive_alu(4'b0101, 32'd1, 32'd2, 1, 1);
            wait_div(sgn, a, b, "div_rnd");
        end
        tick();

        start_div(0, 32'd100, 32'd7);
        clear_d();
        repeat (10) tick();
        chk("mid busy", 32'(div_busy), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        chk("midrst busy", 32'(div_busy), 32'd0);
        chk("midrst ealu", Ealu, 32'd0);
        chk("midrst hi", Ehi, 32'd0);
        chk("midrst lo", Elo, 32'd0);
        chk("midrst w_hi", 32'(Ew_hi), 32'd0);
        chk("midrst w_lo", 32'(Ew_lo), 32'd0);
        chk("midrst ew_rf", 32'(Ew_rf), 32'd0);
        chk("midrst ern", 32'(Ern), 32'd0);
        chk("midrst ert", ERt, 32'd0);
        tick();
        chk("postrst busy", 32'(div_busy), 32'd0);
        chk("postrst lo", Elo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_exe.md
PIPE_EXE -- requirements
Module: pipe_exe

Interface
REQ-001 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-002 Parameter: DIV_CYCLES, default 32, number of divider iterations.
REQ-003 clk  in  1  pipeline clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 Dstall  in  1  ID hazard stall; when high, a bubble is latched.
REQ-006 Dw_rf, Dw_dm, Dw_hi, Dw_lo, Ddiv, Dsign, DisGoto  in  1 each  ID control bits.
REQ-007 Daluc  in  4  ALU op; Dasource, Dbsource  in  1 each  operand selects; Drfsource  in  3  writeback source.
REQ-008 DRs, DRt, Dimm, Dpc4  in  32 each  ID operands; Drn  in  5  destination register.
REQ-009 Ealu  out  32  ALU/link result, forwarded to ID.
REQ-010 Ern  out  5; Ew_rf, Ew_dm, EisGoto  out  1; Erfsource  out  3.
REQ-011 Ehi, Elo  out  32  divider remainder/quotient; Ew_hi, Ew_lo  out  1.
REQ-012 ERt  out  32  store data.
REQ-013 div_busy  out  1  freezes PC, IF/ID and this block's input latch.

Function
REQ-014 ID/EXE latch: on each rising clk with div_busy low, capture all D* inputs; if Dstall is high, zero all write enables and Ddiv instead (bubble).
REQ-015 Operand A is {27'b0, imm[10:6]} when asource=1, else Rs; operand B is imm when bsource=1, else Rt.
REQ-016 aluc encoding:
- 0000 ADDU, 0010 ADD, 0001 SUBU, 0011 SUB
- 0100 AND, 0101 OR, 0110 XOR, 0111 NOR
- 1000 LUI (B<<16)
- 1010 SLT signed, 1011 SLTU
- 1100 SRA, 1110 SLL, 1111 SRL (shift B by A[4:0])
- others yield 0.
REQ-017 ADD/SUB signed overflow forces Ew_rf=0 for that instruction; result value is still driven.
REQ-018 When isGoto=1: Ealu = pc4+4 (delay slot), Ern = 31, Ew_rf = 1.
REQ-019 ALU path is zero-latency: Ealu is valid in the same cycle the latch updates.
REQ-020 Divider FSM states are IDLE, BUSY, DONE; a latched div moves IDLE->BUSY.
REQ-021 BUSY runs DIV_CYCLES restoring-division steps on magnitudes; BUSY->DONE after the last step.
REQ-022 DONE asserts Ew_hi=Ew_lo=1 for exactly one cycle, then returns to IDLE.
REQ-023 div_busy is high in IDLE on the cycle a div is latched, and throughout BUSY.
REQ-024 div_busy is low in DONE; total stall is DIV_CYCLES+1 cycles.
REQ-025 Signed division (sign=1): quotient is negated iff the operand signs differ; remainder takes the dividend's sign.
REQ-026 Divide by zero: Lo=32'hFFFFFFFF, Hi=dividend; timing is unchanged.
REQ-027 Signed 0x80000000/-1 gives Lo=0x80000000, Hi=0.
REQ-028 Ew_rf, Ew_dm, Ew_hi, Ew_lo are 0 for a div instruction except in DONE.
REQ-029 While div_busy is high, Dstall and D* inputs are ignored.
REQ-030 A div latched in the same cycle DONE is asserted starts a new BUSY on the next cycle.

Reset
REQ-031 rst forces IDLE and zeros the latch, all outputs and the divider registers on the next rising clk, including mid-division (result discarded, div_busy=0).

Structure
REQ-032 Shared package holds the aluc codes, rfsource codes, the divider state enum and DIV_CYCLES.
REQ-033 The divider is one sub-module, pipe_div (start, sign, a, b -> busy, done, q, r); the ALU stays inline.

Verification
REQ-034 ADDU Rs=7, Rt=5, aluc=0000 -> Ealu=12, Ew_rf=1 in the cycle after capture.
REQ-035 ADD 0x7FFFFFFF+1 -> Ealu=0x80000000, Ew_rf=0; SLT -3 vs 2 -> Ealu=1.
REQ-036 jal with Dpc4=0x00400008 -> Ealu=0x0040000C, Ern=31, EisGoto=1.
REQ-037 Signed div -7/2 -> div_busy high 33 cycles; DONE shows Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, Ew_hi=Ew_lo=1 for one cycle.
REQ-038 Unsigned div 10/0 -> Lo=0xFFFFFFFF, Hi=10; back-to-back div latched at DONE restarts BUSY.
REQ-039 rst asserted at BUSY step 10 -> next cycle IDLE, div_busy=0, all outputs 0; Dstall=1 -> all write enables 0.
